// File: rtl/pwm_fader.sv
`default_nettype none
// ============================================================================
// Module   : pwm_fader
// Purpose  : Multi-channel PWM generator with per-channel step or ramped duty
//            changes, applied only at period boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_fader #(
  parameter int NCH       = 4,
  parameter int W         = 8,
  parameter int PRESC     = 1,
  parameter int FADE_STEP = 1,
  localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           wr_en,
  input  logic [CW-1:0]  ch_sel,
  input  logic [W-1:0]   target,
  input  logic           fade,
  output logic [NCH-1:0] pwm_out,
  output logic [NCH-1:0] busy,
  output logic           period_start
);

  localparam int            PW           = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] c_PRESC_LAST = PW'(PRESC - 1);
  localparam logic [W-1:0]  c_CTR_LAST   = W'(2 ** W - 2);
  localparam logic [W-1:0]  c_STEP       = W'(FADE_STEP);

  logic          r_run;
  logic          r_started;
  logic [PW-1:0] r_presc;
  logic [W-1:0]  r_ctr;
  logic          w_tick;
  logic          w_pstart;

  // r_run keeps the prescaler idle for one cycle after reset release so no
  // tick (and no period_start) can be decoded while RST_N is still low.
  assign w_tick       = r_run && (r_presc == c_PRESC_LAST);
  assign w_pstart     = w_tick && (!r_started || (r_ctr == c_CTR_LAST));
  assign period_start = w_pstart;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_run     <= 1'b0;
      r_started <= 1'b0;
      r_presc   <= '0;
      r_ctr     <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_tick) begin
        r_presc   <= '0;
        r_started <= 1'b1;
        r_ctr     <= w_pstart ? '0 : r_ctr + 1'b1;
      end else if (r_run) begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam logic [CW-1:0] c_IDX = CW'(i);

    logic [W-1:0] r_target;
    logic [W-1:0] r_active;
    logic         r_fade;
    logic         r_pwm;
    logic         w_wr;
    logic [W-1:0] w_up;
    logic [W-1:0] w_dn;
    logic [W-1:0] w_next;

    // Rewriting the current target leaves target and mode untouched.
    assign w_wr = wr_en && (ch_sel == c_IDX) && (target != r_target);
    assign w_up = r_target - r_active;
    assign w_dn = r_active - r_target;

    always_comb begin
      w_next = r_target;
      if (r_fade) begin
        if (r_active < r_target) begin
          w_next = (w_up > c_STEP) ? r_active + c_STEP : r_target;
        end else if (r_active > r_target) begin
          w_next = (w_dn > c_STEP) ? r_active - c_STEP : r_target;
        end
      end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        r_target <= '0;
        r_fade   <= 1'b0;
        r_active <= '0;
        r_pwm    <= 1'b0;
      end else begin
        if (w_wr) begin
          r_target <= target;
          r_fade   <= fade;
        end
        if (w_pstart) begin
          r_active <= w_next;
        end
        r_pwm <= (r_ctr < r_active);
      end
    end

    assign pwm_out[i] = r_pwm;
    assign busy[i]    = (r_active != r_target);
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_fader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_fader
// Purpose  : Directed self-checking bench for pwm_fader (two configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_fader;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instance A: NCH=2, W=4, PRESC=1, FADE_STEP=4
  logic       a_rst_n = 1'b0;
  logic       a_wr    = 1'b0;
  logic [0:0] a_sel   = '0;
  logic [3:0] a_tgt   = '0;
  logic       a_fade  = 1'b0;
  logic [1:0] a_pwm;
  logic [1:0] a_busy;
  logic       a_ps;

  // Instance B: NCH=3, W=4, PRESC=3, FADE_STEP=6
  logic       b_rst_n = 1'b0;
  logic       b_wr    = 1'b0;
  logic [1:0] b_sel   = '0;
  logic [3:0] b_tgt   = '0;
  logic       b_fade  = 1'b0;
  logic [2:0] b_pwm;
  logic [2:0] b_busy;
  logic       b_ps;

  pwm_fader #(.NCH(2), .W(4), .PRESC(1), .FADE_STEP(4)) u_a (
    .CLK(CLK), .RST_N(a_rst_n), .wr_en(a_wr), .ch_sel(a_sel), .target(a_tgt),
    .fade(a_fade), .pwm_out(a_pwm), .busy(a_busy), .period_start(a_ps)
  );

  pwm_fader #(.NCH(3), .W(4), .PRESC(3), .FADE_STEP(6)) u_b (
    .CLK(CLK), .RST_N(b_rst_n), .wr_en(b_wr), .ch_sel(b_sel), .target(b_tgt),
    .fade(b_fade), .pwm_out(b_pwm), .busy(b_busy), .period_start(b_ps)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Results of the last measurement: per period window, per channel.
  int         m_cnt[4][3];
  bit         m_pref[4][3];
  logic [2:0] m_busy0;
  logic [2:0] m_busy_end[4];
  bit         m_tmo;

  // Pending write used by do_write and by measure's injection point.
  logic [1:0] wv_ch   = '0;
  logic [3:0] wv_val  = '0;
  logic       wv_fade = 1'b0;

  function automatic logic [2:0] pwm_of(input int d);
    return d ? b_pwm : {1'b0, a_pwm};
  endfunction

  function automatic logic [2:0] busy_of(input int d);
    return d ? b_busy : {1'b0, a_busy};
  endfunction

  function automatic logic ps_of(input int d);
    return d ? b_ps : a_ps;
  endfunction

  task automatic drive_wr(input int d, input logic en);
    if (d == 0) begin
      a_wr = en; a_sel = wv_ch[0]; a_tgt = wv_val; a_fade = wv_fade;
    end else begin
      b_wr = en; b_sel = wv_ch; b_tgt = wv_val; b_fade = wv_fade;
    end
  endtask

  task automatic do_write(input int d, input logic [1:0] ch, input logic [3:0] v, input logic f);
    wv_ch = ch; wv_val = v; wv_fade = f;
    @(negedge CLK); drive_wr(d, 1'b1);
    @(negedge CLK); drive_wr(d, 1'b0);
  endtask

  // Align to the next period_start P, then count pwm highs over nper windows
  // of one period each. A window starts two cycles after its period_start
  // (one cycle for the active update, one for the registered output).
  // inj = -2 writes wv_* coincident with P; inj >= 0 writes at that sample
  // index of the first window.
  task automatic measure(input int d, input int nper, input int inj);
    int         n;
    int         guard;
    bit         pend;
    bit         seen_low[3];
    logic [2:0] p;
    n = d ? 45 : 15;
    m_tmo = 1'b0; guard = 0; pend = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 3; c++) begin
        m_cnt[k][c] = 0; m_pref[k][c] = 1'b1;
      end
      m_busy_end[k] = '0;
    end
    while (ps_of(d) !== 1'b1) begin
      if (guard >= 200) begin m_tmo = 1'b1; return; end
      @(negedge CLK); guard++;
    end
    if (inj == -2) begin drive_wr(d, 1'b1); pend = 1'b1; end
    @(negedge CLK);
    if (pend) begin drive_wr(d, 1'b0); pend = 1'b0; end
    m_busy0 = busy_of(d);
    for (int k = 0; k < nper; k++) begin
      for (int c = 0; c < 3; c++) seen_low[c] = 1'b0;
      for (int s = 0; s < n; s++) begin
        @(negedge CLK);
        if (pend) begin drive_wr(d, 1'b0); pend = 1'b0; end
        if (k == 0 && s == inj) begin drive_wr(d, 1'b1); pend = 1'b1; end
        p = pwm_of(d);
        for (int c = 0; c < 3; c++) begin
          if (p[c]) begin
            m_cnt[k][c]++;
            if (seen_low[c]) m_pref[k][c] = 1'b0;
          end else begin
            seen_low[c] = 1'b1;
          end
        end
      end
      m_busy_end[k] = busy_of(d);
    end
    if (pend) begin @(negedge CLK); drive_wr(d, 1'b0); end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge CLK);
    n_chk++; if (a_pwm !== 2'b00) begin n_fail++; $display("FAIL reset a_pwm: got %b, expected 00", a_pwm); end
    n_chk++; if (a_busy !== 2'b00) begin n_fail++; $display("FAIL reset a_busy: got %b, expected 00", a_busy); end
    n_chk++; if (a_ps !== 1'b0) begin n_fail++; $display("FAIL reset a_ps: got %b, expected 0", a_ps); end
    n_chk++; if (b_pwm !== 3'b000) begin n_fail++; $display("FAIL reset b_pwm: got %b, expected 000", b_pwm); end
    n_chk++; if (b_busy !== 3'b000) begin n_fail++; $display("FAIL reset b_busy: got %b, expected 000", b_busy); end
    n_chk++; if (b_ps !== 1'b0) begin n_fail++; $display("FAIL reset b_ps: got %b, expected 0", b_ps); end
    a_rst_n = 1'b1; b_rst_n = 1'b1;
  endtask

  task automatic test_step_extremes;
    do_write(0, 2'd0, 4'd0, 1'b0);
    do_write(0, 2'd1, 4'd15, 1'b0);
    measure(0, 3, -1);
    n_chk++; if (m_tmo !== 1'b0) begin n_fail++; $display("FAIL step_extremes timeout: no period_start"); end
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (m_cnt[k][0] !== 0) begin n_fail++; $display("FAIL step_extremes ch0 period %0d: high %0d, expected 0", k, m_cnt[k][0]); end
      n_chk++; if (m_cnt[k][1] !== 15) begin n_fail++; $display("FAIL step_extremes ch1 period %0d: high %0d, expected 15", k, m_cnt[k][1]); end
    end
    n_chk++; if (m_busy0 !== 3'b000) begin n_fail++; $display("FAIL step_extremes busy: got %b, expected 000", m_busy0); end
  endtask

  task automatic test_fade_up;
    int e[3];
    e = '{4, 8, 9};
    do_write(0, 2'd0, 4'd9, 1'b1);
    measure(0, 3, -1);
    n_chk++; if (m_tmo !== 1'b0) begin n_fail++; $display("FAIL fade_up timeout: no period_start"); end
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (m_cnt[k][0] !== e[k]) begin n_fail++; $display("FAIL fade_up ch0 period %0d: high %0d, expected %0d", k, m_cnt[k][0], e[k]); end
    end
    n_chk++; if (m_busy0[0] !== 1'b1) begin n_fail++; $display("FAIL fade_up busy after 1st: got %b, expected 1", m_busy0[0]); end
    n_chk++; if (m_busy_end[0][0] !== 1'b1) begin n_fail++; $display("FAIL fade_up busy after 2nd: got %b, expected 1", m_busy_end[0][0]); end
    n_chk++; if (m_busy_end[1][0] !== 1'b0) begin n_fail++; $display("FAIL fade_up busy after 3rd: got %b, expected 0", m_busy_end[1][0]); end
  endtask

  task automatic test_mid_period_write;
    wv_ch = 2'd0; wv_val = 4'd3; wv_fade = 1'b0;
    measure(0, 2, 5);
    n_chk++; if (m_tmo !== 1'b0) begin n_fail++; $display("FAIL mid_period timeout: no period_start"); end
    n_chk++; if (m_cnt[0][0] !== 9) begin n_fail++; $display("FAIL mid_period current period: high %0d, expected 9", m_cnt[0][0]); end
    n_chk++; if (m_cnt[1][0] !== 3) begin n_fail++; $display("FAIL mid_period next period: high %0d, expected 3", m_cnt[1][0]); end
  endtask

  task automatic test_coincident_write;
    int e[3];
    e = '{3, 12, 12};
    wv_ch = 2'd0; wv_val = 4'd12; wv_fade = 1'b0;
    measure(0, 3, -2);
    n_chk++; if (m_tmo !== 1'b0) begin n_fail++; $display("FAIL coincident timeout: no period_start"); end
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (m_cnt[k][0] !== e[k]) begin n_fail++; $display("FAIL coincident ch0 period %0d: high %0d, expected %0d", k, m_cnt[k][0], e[k]); end
    end
  endtask

  task automatic test_noop_rewrite;
    int e[3];
    e = '{8, 4, 0};
    do_write(0, 2'd0, 4'd0, 1'b1);
    wv_ch = 2'd0; wv_val = 4'd0; wv_fade = 1'b1;
    measure(0, 3, 5);
    n_chk++; if (m_tmo !== 1'b0) begin n_fail++; $display("FAIL noop_rewrite timeout: no period_start"); end
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (m_cnt[k][0] !== e[k]) begin n_fail++; $display("FAIL noop_rewrite ch0 period %0d: high %0d, expected %0d", k, m_cnt[k][0], e[k]); end
    end
  endtask

  task automatic test_prescaler;
    do_write(1, 2'd0, 4'd5, 1'b0);
    measure(1, 2, -1);
    n_chk++; if (m_tmo !== 1'b0) begin n_fail++; $display("FAIL prescaler timeout: no period_start"); end
    for (int k = 0; k < 2; k++) begin
      n_chk++; if (m_cnt[k][0] !== 15) begin n_fail++; $display("FAIL prescaler ch0 period %0d: high %0d, expected 15", k, m_cnt[k][0]); end
      n_chk++; if (m_pref[k][0] !== 1'b1) begin n_fail++; $display("FAIL prescaler shape period %0d: contiguous=%b, expected 1", k, m_pref[k][0]); end
    end
  endtask

  task automatic test_fade_down;
    int e[3];
    e = '{27, 9, 0};
    do_write(1, 2'd0, 4'd15, 1'b0);
    measure(1, 1, -1);
    n_chk++; if (m_cnt[0][0] !== 45) begin n_fail++; $display("FAIL fade_down preload: high %0d, expected 45", m_cnt[0][0]); end
    do_write(1, 2'd0, 4'd0, 1'b1);
    measure(1, 3, -1);
    n_chk++; if (m_tmo !== 1'b0) begin n_fail++; $display("FAIL fade_down timeout: no period_start"); end
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (m_cnt[k][0] !== e[k]) begin n_fail++; $display("FAIL fade_down ch0 period %0d: high %0d, expected %0d", k, m_cnt[k][0], e[k]); end
    end
    n_chk++; if (m_busy_end[0][0] !== 1'b1) begin n_fail++; $display("FAIL fade_down busy after 2nd: got %b, expected 1", m_busy_end[0][0]); end
    n_chk++; if (m_busy_end[1][0] !== 1'b0) begin n_fail++; $display("FAIL fade_down busy after 3rd: got %b, expected 0", m_busy_end[1][0]); end
  endtask

  task automatic test_reset_mid_fade;
    do_write(1, 2'd0, 4'd15, 1'b1);
    measure(1, 1, -1);
    n_chk++; if (m_cnt[0][0] !== 18) begin n_fail++; $display("FAIL reset_mid_fade first step: high %0d, expected 18", m_cnt[0][0]); end
    @(negedge CLK);
    n_chk++; if (b_pwm[0] !== 1'b1) begin n_fail++; $display("FAIL reset_mid_fade pre pwm: got %b, expected 1", b_pwm[0]); end
    n_chk++; if (b_busy[0] !== 1'b1) begin n_fail++; $display("FAIL reset_mid_fade pre busy: got %b, expected 1", b_busy[0]); end
    #1 b_rst_n = 1'b0;
    #1;
    n_chk++; if (b_pwm !== 3'b000) begin n_fail++; $display("FAIL async_reset pwm: got %b, expected 000", b_pwm); end
    n_chk++; if (b_busy !== 3'b000) begin n_fail++; $display("FAIL async_reset busy: got %b, expected 000", b_busy); end
    n_chk++; if (b_ps !== 1'b0) begin n_fail++; $display("FAIL async_reset ps: got %b, expected 0", b_ps); end
    repeat (2) @(negedge CLK);
    b_rst_n = 1'b1;
    do_write(1, 2'd1, 4'd7, 1'b0);
    measure(1, 1, -1);
    n_chk++; if (m_tmo !== 1'b0) begin n_fail++; $display("FAIL post_reset timeout: no period_start"); end
    n_chk++; if (m_cnt[0][0] !== 0) begin n_fail++; $display("FAIL post_reset ch0: high %0d, expected 0", m_cnt[0][0]); end
    n_chk++; if (m_cnt[0][1] !== 21) begin n_fail++; $display("FAIL post_reset ch1: high %0d, expected 21", m_cnt[0][1]); end
    n_chk++; if (m_busy0 !== 3'b000) begin n_fail++; $display("FAIL post_reset busy: got %b, expected 000", m_busy0); end
  endtask

  task automatic test_out_of_range;
    int e[3];
    e = '{0, 21, 0};
    do_write(1, 2'd3, 4'd11, 1'b0);
    n_chk++; if (b_busy !== 3'b000) begin n_fail++; $display("FAIL out_of_range busy: got %b, expected 000", b_busy); end
    measure(1, 1, -1);
    n_chk++; if (m_tmo !== 1'b0) begin n_fail++; $display("FAIL out_of_range timeout: no period_start"); end
    for (int c = 0; c < 3; c++) begin
      n_chk++; if (m_cnt[0][c] !== e[c]) begin n_fail++; $display("FAIL out_of_range ch%0d: high %0d, expected %0d", c, m_cnt[0][c], e[c]); end
    end
  endtask

  initial begin
    test_reset;
    test_step_extremes;
    test_fade_up;
    test_mid_period_write;
    test_coincident_write;
    test_noop_rewrite;
    test_prescaler;
    test_fade_down;
    test_reset_mid_fade;
    test_out_of_range;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
